// File: rtl/stopwatch_counter_if.sv
// ---------------------------------------------------------------------------
// stopwatch_counter_if
// Bundles the control pulses, mode inputs and BCD digit outputs of the
// stopwatch timekeeping core.
//   tick_1hz  : one-cycle count enable (1 Hz)
//   tick_adj  : one-cycle adjust enable (~5 Hz)
//   btn_pause : debounced pause level, rising edge toggles run/pause
//   adj       : adjust mode when high
//   adj_sel   : bit0=1 seconds field, bit0=0 minutes field
//   min_l/min_r/sec_l/sec_r : BCD digits (5 bits, bit4 always 0)
//   running   : high while counting
//   wrap      : one-cycle pulse on MAX_MIN:59 -> 00:00 rollover
// master drives the controls and reads the digits; slave is the core.
// ---------------------------------------------------------------------------
interface stopwatch_counter_if;
   logic       tick_1hz;
   logic       tick_adj;
   logic       btn_pause;
   logic       adj;
   logic [2:0] adj_sel;
   logic [4:0] min_l;
   logic [4:0] min_r;
   logic [4:0] sec_l;
   logic [4:0] sec_r;
   logic       running;
   logic       wrap;

   modport master (
      output tick_1hz, tick_adj, btn_pause, adj, adj_sel,
      input  min_l, min_r, sec_l, sec_r, running, wrap
   );

   modport slave (
      input  tick_1hz, tick_adj, btn_pause, adj, adj_sel,
      output min_l, min_r, sec_l, sec_r, running, wrap
   );
endinterface

// File: rtl/stopwatch_counter.sv
// ---------------------------------------------------------------------------
// stopwatch_counter
// MM:SS timekeeping core held as four BCD digits. Counts on tick_1hz while
// running, supports pause/resume on the rising edge of btn_pause, and a
// per-field adjust mode advanced by tick_adj.
// Ports:
//   clk       : system clock
//   btn_reset : synchronous active-high reset, highest priority
//   bus       : stopwatch_counter_if.slave (controls in, digits/status out)
// Parameter:
//   MAX_MIN   : highest minute value before wrap to 00 (1..99)
// ---------------------------------------------------------------------------
module stopwatch_counter #(
   parameter int MAX_MIN = 99
) (
   input  logic                  clk,
   input  logic                  btn_reset,
   stopwatch_counter_if.slave    bus
);

   localparam logic [3:0] MAX_TENS  = 4'(MAX_MIN / 10);
   localparam logic [3:0] MAX_UNITS = 4'(MAX_MIN % 10);

   // ADJ_P / ADJ_R remember which state to return to when adj drops.
   typedef enum logic [1:0] {
      PAUSED = 2'd0,
      RUN    = 2'd1,
      ADJ_P  = 2'd2,
      ADJ_R  = 2'd3
   } state_t;

   state_t     state_reg, state_next;
   logic       btn_pause_q_reg;
   logic [3:0] min_l_reg, min_l_next;
   logic [3:0] min_r_reg, min_r_next;
   logic [3:0] sec_l_reg, sec_l_next;
   logic [3:0] sec_r_reg, sec_r_next;
   logic       wrap_reg, wrap_next;

   logic       pause_edge;
   logic       at_max_min;
   logic       sec_at_59;
   logic [3:0] min_l_inc, min_r_inc;
   logic [3:0] sec_l_inc, sec_r_inc;

   assign pause_edge = bus.btn_pause & ~btn_pause_q_reg;
   assign at_max_min = (min_l_reg == MAX_TENS) && (min_r_reg == MAX_UNITS);
   assign sec_at_59  = (sec_l_reg == 4'd5) && (sec_r_reg == 4'd9);

   // Incremented minute field, folding MAX_MIN back to 00. Shared by the
   // counting carry and by minute adjust.
   always_comb begin
      min_l_inc = min_l_reg;
      min_r_inc = min_r_reg;
      if (at_max_min) begin
         min_l_inc = 4'd0;
         min_r_inc = 4'd0;
      end else if (min_r_reg == 4'd9) begin
         min_l_inc = min_l_reg + 4'd1;
         min_r_inc = 4'd0;
      end else begin
         min_r_inc = min_r_reg + 4'd1;
      end
   end

   // Incremented seconds field, 59 -> 00. Carry into minutes is decided by
   // the caller so adjust mode can suppress it.
   always_comb begin
      sec_l_inc = sec_l_reg;
      sec_r_inc = sec_r_reg;
      if (sec_r_reg == 4'd9) begin
         sec_r_inc = 4'd0;
         sec_l_inc = (sec_l_reg == 4'd5) ? 4'd0 : sec_l_reg + 4'd1;
      end else begin
         sec_r_inc = sec_r_reg + 4'd1;
      end
   end

   // Next-state and datapath. Ticks act on the current state; the state
   // change takes effect for the following cycle.
   always_comb begin
      state_next = state_reg;
      min_l_next = min_l_reg;
      min_r_next = min_r_reg;
      sec_l_next = sec_l_reg;
      sec_r_next = sec_r_reg;
      wrap_next  = 1'b0;

      case (state_reg)
         RUN: begin
            if (bus.tick_1hz) begin
               sec_l_next = sec_l_inc;
               sec_r_next = sec_r_inc;
               if (sec_at_59) begin
                  min_l_next = min_l_inc;
                  min_r_next = min_r_inc;
                  wrap_next  = at_max_min;
               end
            end
         end
         ADJ_P, ADJ_R: begin
            if (bus.tick_adj) begin
               if (bus.adj_sel[0]) begin
                  sec_l_next = sec_l_inc;
                  sec_r_next = sec_r_inc;
               end else begin
                  min_l_next = min_l_inc;
                  min_r_next = min_r_inc;
               end
            end
         end
         default: begin
         end
      endcase

      // adj has priority over a coincident pause edge, which is dropped.
      case (state_reg)
         PAUSED: begin
            if (bus.adj)
               state_next = ADJ_P;
            else if (pause_edge)
               state_next = RUN;
         end
         RUN: begin
            if (bus.adj)
               state_next = ADJ_R;
            else if (pause_edge)
               state_next = PAUSED;
         end
         ADJ_P: begin
            if (!bus.adj)
               state_next = PAUSED;
         end
         ADJ_R: begin
            if (!bus.adj)
               state_next = RUN;
         end
         default: state_next = PAUSED;
      endcase
   end

   always_ff @(posedge clk) begin
      if (btn_reset) begin
         state_reg       <= PAUSED;
         // Preset high so a button held through reset is not seen as a press.
         btn_pause_q_reg <= 1'b1;
         min_l_reg       <= 4'd0;
         min_r_reg       <= 4'd0;
         sec_l_reg       <= 4'd0;
         sec_r_reg       <= 4'd0;
         wrap_reg        <= 1'b0;
      end else begin
         state_reg       <= state_next;
         btn_pause_q_reg <= bus.btn_pause;
         min_l_reg       <= min_l_next;
         min_r_reg       <= min_r_next;
         sec_l_reg       <= sec_l_next;
         sec_r_reg       <= sec_r_next;
         wrap_reg        <= wrap_next;
      end
   end

   assign bus.min_l   = {1'b0, min_l_reg};
   assign bus.min_r   = {1'b0, min_r_reg};
   assign bus.sec_l   = {1'b0, sec_l_reg};
   assign bus.sec_r   = {1'b0, sec_r_reg};
   assign bus.running = (state_reg == RUN);
   assign bus.wrap    = wrap_reg;

endmodule

// File: doc/stopwatch_counter.md
Name: stopwatch_counter

Overview:
Timekeeping core of the stopwatch. It holds the MM:SS count as four BCD digits and advances it on 1 Hz enable pulses. It supports pause/resume and a per-field adjust mode driven by adjust-rate pulses. Its digit outputs feed the display block directly: min_l, min_r, sec_l, sec_r, plus the same adj/adj_sel controls.

Parameters:
MAX_MIN, 99, highest minute value before wrap to 00; legal range 1..99.

Ports:
clk  input  1  system clock
btn_reset  input  1  synchronous active-high reset
tick_1hz  input  1  one-cycle count enable pulse, 1 Hz, from clkdiv
tick_adj  input  1  one-cycle adjust enable pulse, ~5 Hz, from clkdiv
btn_pause  input  1  debounced pause level; rising edge toggles run/pause
adj  input  1  adjust mode when high
adj_sel  input  3  field select; bit0=1 selects seconds, bit0=0 selects minutes; bits[2:1] ignored
min_l  output  5  minutes tens digit, 0..9, bit4 always 0
min_r  output  5  minutes units digit, 0..9
sec_l  output  5  seconds tens digit, 0..5
sec_r  output  5  seconds units digit, 0..9
running  output  1  high in RUN state
wrap  output  1  one-cycle pulse when the count rolls MAX_MIN:59 -> 00:00

Behaviour:
- All state is registered on the clk rising edge. The reset is synchronous, active-high and has priority over everything.
- Reset values:
  - all digits 0
  - running=0
  - wrap=0
  - state=PAUSED
  - btn_pause edge register=1, so a button held through reset does not toggle on release.
- Pause edge detect: pause_edge = btn_pause & ~btn_pause_q, where btn_pause_q is a one-cycle delayed copy.
- States: PAUSED, RUN, ADJ_P, ADJ_R. The ADJ_* states record which state to resume after adjust.
  - PAUSED: pause_edge -> RUN; adj=1 -> ADJ_P.
  - RUN: pause_edge -> PAUSED; adj=1 -> ADJ_R.
  - ADJ_P/ADJ_R: adj=0 -> PAUSED/RUN respectively; pause_edge is ignored.
  - If adj=1 and pause_edge occur in the same cycle, the adj transition wins and the edge is dropped.
- Counting (RUN only, on a cycle with tick_1hz=1):
  - sec_r increments; 9 -> 0 with carry into sec_l.
  - sec_l 5 -> 0 with carry into min_r.
  - min_r 9 -> 0 with carry into min_l.
  - At MAX_MIN:59 the next tick gives 00:00 and wrap=1 for exactly one cycle.
- Pause and tick in the same cycle: the tick is evaluated against the current state. RUN+tick counts, then the state moves to PAUSED. PAUSED+tick does not count.
- Adjust: in ADJ_* on a cycle with tick_adj=1, only the selected field increments, and tick_1hz is ignored.
  - Seconds field: 00..59, 59 -> 00, no carry into minutes.
  - Minutes field: 00..MAX_MIN, MAX_MIN -> 00.
  - wrap is never asserted in adjust.
- adj_sel may change at any cycle; the new value takes effect on the next tick_adj.
- Outputs are registered with one-cycle latency: the new digits are visible the cycle after the tick is sampled.
- Digits never leave BCD range, including after reset mid-count.
- running = (state==RUN). It is 0 in both ADJ states.

Test Plan:
1. Reset, then btn_pause 0->1, then 75 tick_1hz pulses -> running=1; digits 0,1,1,5 (01:15); wrap never asserted.
2. Preload to 99:58 via adjust (minutes 99 presses, seconds 58 presses), exit adj, resume, 2 tick_1hz -> 99:59, then 00:00 with wrap high exactly one cycle.
3. RUN at 00:10, pause edge coincident with tick_1hz -> 00:11 and running=0; 5 further ticks -> still 00:11.
4. Adjust with adj_sel=3'b101 (seconds) from 00:58: 3 tick_adj -> 00:59, 00:00, 00:01, minutes unchanged. Concurrent tick_1hz pulses are ignored. Drop adj -> returns to prior RUN/PAUSED state.
5. Enter adj while btn_pause toggles -> state unchanged on exit; minutes adjust with adj_sel=3'b100 wraps 99 -> 00.
6. Assert btn_reset mid-count at 12:34 while btn_pause is held high -> next cycle 00:00, running=0; releasing btn_pause causes no toggle; next rising edge -> RUN.
